serial_add_seq: RTL and testbench
=================================

SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width in bits (legal range 2..32).
REQ-002 CLK  input  1  single clock; all state SHALL change only on its rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 Start  input  1  request an operation; sampled only in IDLE.
REQ-005 Sub  input  1  mode select: 0 = A+B+Cin, 1 = A-B (two's complement).
REQ-006 A  input  WIDTH  first operand; captured on Start acceptance.
REQ-007 B  input  WIDTH  second operand; captured on Start acceptance.
REQ-008 Cin  input  1  carry-in for add mode; ignored when Sub=1.
REQ-009 Busy  output  1  high while an operation is in progress (RUN state).
REQ-010 Done  output  1  single-cycle pulse marking a valid result.
REQ-011 Sum  output  WIDTH  registered result.
REQ-012 Cout  output  1  final carry out of the MSB.
REQ-013 Ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 The block SHALL compute the WIDTH-bit sum bit-serially, LSB first, through one shared 1-bit full-adder cell, one bit per clock.
REQ-015 FSM states SHALL be IDLE, RUN and DONE; IDLE->RUN on Start=1; RUN->DONE after exactly WIDTH RUN cycles; DONE->IDLE unconditionally after one cycle.
REQ-016 On Start acceptance the block SHALL load A and B into shift registers, clear the bit counter, and preload the carry register with Cin (Sub=0) or 1 (Sub=1); Sub SHALL be latched for the whole operation.
REQ-017 Each RUN cycle SHALL apply A_sh[0], B_sh[0] XOR Sub_q and carry_q to the cell, shift the sum bit into the partial-result MSB, shift both operands right, and update carry_q with the cell carry.
REQ-018 During the final RUN cycle (counter = WIDTH-1) the block SHALL record the carry into the MSB for Ovf.
REQ-019 Sum, Cout and Ovf SHALL update only on the RUN->DONE transition and hold until the next completion or reset; partial results SHALL never appear on Sum.
REQ-020 Latency: with Start accepted at edge k, Done SHALL be high during the cycle following edge k+WIDTH, and Busy SHALL be high for exactly WIDTH cycles.
REQ-021 Start SHALL be ignored in RUN and DONE; operand changes after acceptance SHALL not affect the result.
REQ-022 Start held high continuously SHALL start a new operation on every return to IDLE, i.e. every WIDTH+2 cycles.
REQ-023 In subtract mode Cout SHALL be the raw adder carry (1 = no borrow).

Reset
REQ-024 RST=1 at a clock edge SHALL force IDLE and clear the counter, shift registers, carry, Sum, Cout, Ovf, Busy and Done to 0, including mid-operation (abort with no Done pulse).
REQ-025 Start asserted in the same cycle as RST SHALL be ignored.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (IDLE, RUN, DONE), the default WIDTH, and the counter-width calculation.
REQ-027 The existing 1-bit full-adder cell (Fulladder) SHALL be instantiated exactly once as the only arithmetic sub-module; no other adder logic is allowed.
REQ-028 The implementation SHALL be 120-400 lines of RTL and have no combinational path from inputs to outputs.

Verification (WIDTH=8)
REQ-029 A=0x3C, B=0x1A, Cin=0, Sub=0 -> Done at cycle 9 after acceptance; Sum=0x56, Cout=0, Ovf=0.
REQ-030 A=0xFF, B=0x01, Cin=1, Sub=0 -> Sum=0x01, Cout=1, Ovf=0; A=0x7F, B=0x01, Cin=0 -> Sum=0x80, Ovf=1.
REQ-031 A=0x05, B=0x07, Sub=1, Cin=1 -> Sum=0xFE, Cout=0 (borrow), Ovf=0; Cin SHALL have no effect.
REQ-032 Start pulsed during RUN with different A/B -> ignored; the first result is unchanged and only one Done pulse occurs.
REQ-033 RST asserted on RUN cycle 4 -> next cycle IDLE, all outputs 0, no Done; a new Start then completes normally.
REQ-034 Start held high for 30 cycles with a constant operand -> Done pulses spaced exactly 10 cycles apart, with Busy low in each DONE and IDLE cycle.

Source files
------------

// File: rtl/serial_add_seq_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding,
// default operand width and the bit-counter width calculation.
package serial_add_seq_pkg;

  // Operation phases: wait for a request, shift bits through the cell,
  // present the result for one cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bits needed to count 0..w-1, never fewer than one.
  function automatic int cnt_width(input int w);
    int bits;
    bits = $clog2(w);
    if (bits < 1) begin
      bits = 1;
    end else begin
      bits = bits;
    end
    return bits;
  endfunction

endpackage

// File: rtl/serial_add_seq_fulladder.sv
// Single-bit full-adder cell; the only arithmetic element of the serial
// adder, reused for every bit position.
module Fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p_s;

  assign p_s = a ^ b;
  assign s   = p_s ^ ci;
  assign co  = (a & b) | (ci & p_s);

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder/subtractor. Operands are shifted LSB first
// through one full-adder cell, one bit per clock; the assembled result,
// carry out and signed overflow are published together when the last bit
// has been processed, so Sum never shows a partial value.
module serial_add_seq
  import serial_add_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] part_r;
  logic             sub_r;
  logic             carry_r;

  logic             fa_a_s;
  logic             fa_b_s;
  logic             fa_sum_s;
  logic             fa_co_s;
  logic [WIDTH-1:0] part_next_s;
  logic             last_s;

  // Present the current operand bits to the cell (B inverted when
  // subtracting) and form the partial result with the new bit at the MSB.
  always_comb begin
    fa_a_s      = a_sh_r[0];
    fa_b_s      = b_sh_r[0] ^ sub_r;
    part_next_s = WIDTH'({fa_sum_s, part_r} >> 1'b1);
    last_s      = (cnt_r == LAST);
  end

  Fulladder u_fa (
    .a  (fa_a_s),
    .b  (fa_b_s),
    .ci (carry_r),
    .s  (fa_sum_s),
    .co (fa_co_s)
  );

  // Control FSM plus datapath registers; every output is registered here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      part_r  <= '0;
      sub_r   <= 1'b0;
      carry_r <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Sum     <= '0;
      Cout    <= 1'b0;
      Ovf     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            a_sh_r  <= A;
            b_sh_r  <= B;
            part_r  <= '0;
            cnt_r   <= '0;
            sub_r   <= Sub;
            // Subtraction is A + ~B + 1, so the +1 rides in on the carry.
            carry_r <= Sub ? 1'b1 : Cin;
            Busy    <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            Busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh_r  <= a_sh_r >> 1'b1;
          b_sh_r  <= b_sh_r >> 1'b1;
          part_r  <= part_next_s;
          carry_r <= fa_co_s;
          cnt_r   <= cnt_r + ONE;
          if (last_s) begin
            // carry_r is the carry into the MSB on this final bit.
            Sum     <= part_next_s;
            Cout    <= fa_co_s;
            Ovf     <= carry_r ^ fa_co_s;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            Busy    <= 1'b1;
            Done    <= 1'b0;
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          Busy    <= 1'b0;
          Done    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          Busy    <= 1'b0;
          Done    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq (WIDTH=8): directed corner cases
// plus random operations compared against an arithmetic reference model.
module tb_serial_add_seq;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         Start;
  logic         Sub;
  logic         Cin;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovf;

  int checks = 0;
  int errors = 0;

  serial_add_seq #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .Start (Start),
    .Sub   (Sub),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Busy  (Busy),
    .Done  (Done),
    .Sum   (Sum),
    .Cout  (Cout),
    .Ovf   (Ovf)
  );

  always #5 CLK = ~CLK;

  // Reference: plain integer arithmetic. Returns {ovf, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] bop;
    int unsigned  c;
    int unsigned  u;
    int           sa;
    int           sb;
    int           s;
    logic         ovf;
    bop = sub ? ~b : b;
    c   = sub ? 1 : int'(cin);
    u   = int'(a) + int'(bop) + c;
    sa  = $signed(a);
    sb  = $signed(bop);
    s   = sa + sb + int'(c);
    ovf = (s > 127) || (s < -128);
    return {ovf, u[W], u[W-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one operation from IDLE, scramble inputs after acceptance, then
  // check Busy, latency, results and the single-cycle Done pulse.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input string tag);
    logic [W+1:0] exp;
    int           lat;
    exp   = model(a, b, cin, sub);
    A     = a;
    B     = b;
    Cin   = cin;
    Sub   = sub;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    Cin   = 1'($urandom);
    Sub   = 1'($urandom);
    lat   = 0;
    while (Done !== 1'b1 && lat < 20) begin
      chk({tag, "_busy"}, 32'(Busy), 32'd1);
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd8);
    chk({tag, "_done"}, 32'(Done), 32'd1);
    chk({tag, "_busy_done"}, 32'(Busy), 32'd0);
    chk({tag, "_sum"}, 32'(Sum), 32'(exp[W-1:0]));
    chk({tag, "_cout"}, 32'(Cout), 32'(exp[W]));
    chk({tag, "_ovf"}, 32'(Ovf), 32'(exp[W+1]));
    tick();
    chk({tag, "_pulse"}, 32'(Done), 32'd0);
  endtask

  initial begin
    int dones;
    int last_done;
    int prev_done;

    // Reset with Start held high: the request must be ignored.
    RST   = 1'b1;
    Start = 1'b1;
    Sub   = 1'b0;
    Cin   = 1'b0;
    A     = 8'h11;
    B     = 8'h22;
    repeat (3) tick();
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_sum", 32'(Sum), 32'd0);
    chk("rst_cout", 32'(Cout), 32'd0);
    chk("rst_ovf", 32'(Ovf), 32'd0);
    RST   = 1'b0;
    Start = 1'b0;
    tick();
    chk("idle_busy", 32'(Busy), 32'd0);

    // Directed corner operations.
    run_op(8'h3C, 8'h1A, 1'b0, 1'b0, "add_basic");
    chk("add_basic_const", 32'(Sum), 32'h56);
    run_op(8'hFF, 8'h01, 1'b1, 1'b0, "add_carry");
    chk("add_carry_const", 32'(Sum), 32'h01);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, "add_ovf");
    chk("add_ovf_const", 32'(Ovf), 32'd1);
    run_op(8'h05, 8'h07, 1'b1, 1'b1, "sub_cin1");
    chk("sub_cin1_const", 32'(Sum), 32'hFE);
    run_op(8'h05, 8'h07, 1'b0, 1'b1, "sub_cin0");
    chk("sub_cin0_const", 32'(Sum), 32'hFE);
    run_op(8'h80, 8'h01, 1'b0, 1'b1, "sub_ovf");

    // Start pulsed mid-operation with different operands is ignored.
    A = 8'h3C; B = 8'h1A; Cin = 1'b0; Sub = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    A = 8'h99; B = 8'h77; Sub = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0;
    last_done = 0;
    while (Done !== 1'b1 && last_done < 20) begin
      tick();
      last_done++;
    end
    chk("ign_done", 32'(Done), 32'd1);
    chk("ign_sum", 32'(Sum), 32'h56);
    dones = 0;
    repeat (12) begin
      tick();
      if (Done === 1'b1) dones++;
    end
    chk("ign_one_pulse", 32'(dones), 32'd0);

    // Reset during the fourth RUN cycle aborts without a Done pulse.
    A = 8'hF0; B = 8'h0F; Cin = 1'b1; Sub = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (3) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_sum", 32'(Sum), 32'd0);
    chk("abort_cout", 32'(Cout), 32'd0);
    chk("abort_ovf", 32'(Ovf), 32'd0);
    dones = 0;
    repeat (12) begin
      tick();
      if (Done === 1'b1 || Busy === 1'b1) dones++;
    end
    chk("abort_quiet", 32'(dones), 32'd0);
    run_op(8'hA5, 8'h5A, 1'b1, 1'b0, "after_abort");

    // Start held high: results every W+2 cycles, Busy low in DONE and IDLE.
    A = 8'h64; B = 8'h32; Cin = 1'b1; Sub = 1'b0; Start = 1'b1;
    dones     = 0;
    last_done = 0;
    prev_done = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (prev_done != 0) chk("hold_idle_busy", 32'(Busy), 32'd0);
      prev_done = 0;
      if (Done === 1'b1) begin
        chk("hold_done_busy", 32'(Busy), 32'd0);
        chk("hold_sum", 32'(Sum), 32'h97);
        if (dones > 0) chk("hold_spacing", 32'(i - last_done), 32'd10);
        else chk("hold_first", 32'(i), 32'd9);
        dones++;
        last_done = i;
        prev_done = 1;
      end
    end
    Start = 1'b0;
    chk("hold_count", 32'(dones), 32'd3);
    tick();

    // Random operations against the model.
    for (int n = 0; n < 20; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
